// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one radix-2 shift-add or restoring-divide
// step per cycle, valid/ready on request and response.
module muldiv_seq #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic            busy
);

   localparam int unsigned     CW      = $clog2(XLEN);
   localparam logic [CW-1:0]   CntLast = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] Ones    = '1;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic                neg_q, neg_d;
   logic                spec_q, spec_d;
   logic                vld_q, vld_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     dvs_q, dvs_d;
   logic [XLEN-1:0]     res_q, res_d;

   // Request decode: operand signedness, magnitudes and the short-circuit cases.
   logic            in_div, in_signed_a, in_signed_b, in_sa, in_sb, in_neg;
   logic            in_div_zero, in_ovf, in_special, accept;
   logic [XLEN-1:0] in_mag_a, in_mag_b, in_spec_res;

   assign in_div      = req_funct3[2];
   assign in_signed_a = in_div ? ~req_funct3[0]
                               : (req_funct3[1:0] == 2'b01 || req_funct3[1:0] == 2'b10);
   assign in_signed_b = in_div ? ~req_funct3[0] : (req_funct3[1:0] == 2'b01);
   assign in_sa       = in_signed_a & req_a[XLEN-1];
   assign in_sb       = in_signed_b & req_b[XLEN-1];
   assign in_mag_a    = in_sa ? -req_a : req_a;
   assign in_mag_b    = in_sb ? -req_b : req_b;
   // Remainder follows the dividend sign; everything else follows the product/quotient sign.
   assign in_neg      = (in_div && req_funct3[1]) ? in_sa : (in_sa ^ in_sb);
   assign in_div_zero = in_div && (req_b == '0);
   assign in_ovf      = in_div && !req_funct3[0] && (req_a == MinInt) && (req_b == Ones);
   assign in_special  = in_div_zero || in_ovf;
   assign in_spec_res = in_div_zero ? (req_funct3[1] ? req_a : Ones)
                                    : (req_funct3[1] ? '0 : MinInt);

   assign req_ready  = (state_q == StIdle) && !flush;
   assign accept     = req_valid && req_ready;
   assign resp_valid = vld_q;
   assign resp_data  = res_q;
   assign busy       = (state_q != StIdle);

   // One iteration step and final sign/half selection.
   logic [XLEN:0]      mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0]  step, prod;
   logic [XLEN-1:0]    div_sel, div_res, mul_res, fin_res;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, dvs_q};
      if (op_q[2]) begin
         step = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         step = {mul_sum, acc_q[XLEN-1:1]};
      end
      prod    = neg_q ? -acc_q : acc_q;
      mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      div_sel = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      div_res = neg_q ? -div_sel : div_sel;
      fin_res = op_q[2] ? div_res : mul_res;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_d   = neg_q;
      spec_d  = spec_q;
      vld_d   = vld_q;
      acc_d   = acc_q;
      dvs_d   = dvs_q;
      res_d   = res_q;
      unique case (state_q)
         StIdle: begin
            vld_d = 1'b0;
            if (accept) begin
               op_d   = req_funct3;
               neg_d  = in_neg;
               spec_d = in_special;
               cnt_d  = '0;
               if (in_special) begin
                  res_d   = in_spec_res;
                  state_d = StDone;
               end else begin
                  // Divide: {rem, quot} starts as {0, |a|}. Multiply: low half holds |b|.
                  acc_d   = {{XLEN{1'b0}}, in_div ? in_mag_a : in_mag_b};
                  dvs_d   = in_div ? in_mag_b : in_mag_a;
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            // First DONE cycle applies the sign fix-up; the response is offered after it.
            if (!vld_q) begin
               vld_d = 1'b1;
               if (!spec_q) res_d = fin_res;
            end else if (resp_ready) begin
               vld_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d = StIdle;
         vld_d   = 1'b0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         spec_q  <= 1'b0;
         vld_q   <= 1'b0;
         acc_q   <= '0;
         dvs_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         spec_q  <= spec_d;
         vld_q   <= vld_d;
         acc_q   <= acc_d;
         dvs_q   <= dvs_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table for results/latency, hand sequences for
// response back-pressure, flush and mid-operation reset.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_data;
   logic        busy;

   int checks = 0;
   int errors = 0;

   muldiv_seq #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_funct3(req_funct3),
      .req_a     (req_a),
      .req_b     (req_b),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_data (resp_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
   localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Present a request at a negedge; it is accepted at the following posedge.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int g = 0;
      @(negedge clk);
      while (!req_ready && g < 60) begin
         @(negedge clk);
         g++;
      end
      if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_funct3 = f;
      req_a      = a;
      req_b      = b;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_funct3 = ~f;
      req_a      = 32'hDEAD_BEEF;
      req_b      = 32'h1234_5678;
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      while (!resp_valid && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic consume();
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[18];
      int   n;
      bit   seen;

      vecs[0]  = '{"mul_7x6",       MUL,    32'd7,          32'd6,          32'd42,         33};
      vecs[1]  = '{"mulh_m1xm1",    MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          33};
      vecs[2]  = '{"mulhu_m1xm1",   MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33};
      vecs[3]  = '{"mulhsu_m1x2",   MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33};
      vecs[4]  = '{"div_m7_2",      DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
      vecs[5]  = '{"rem_m7_2",      REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
      vecs[6]  = '{"divu_100_7",    DIVU,   32'd100,        32'd7,          32'd14,         33};
      vecs[7]  = '{"remu_100_7",    REMU,   32'd100,        32'd7,          32'd2,          33};
      vecs[8]  = '{"divu_5_0",      DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  1};
      vecs[9]  = '{"remu_5_0",      REMU,   32'd5,          32'd0,          32'd5,          1};
      vecs[10] = '{"div_ovf",       DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
      vecs[11] = '{"rem_ovf",       REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1};
      vecs[12] = '{"div_m5_0",      DIV,    32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1};
      vecs[13] = '{"rem_m5_0",      REM,    32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
      vecs[14] = '{"mulh_min_x2",   MULH,   32'h8000_0000,  32'd2,          32'hFFFF_FFFF,  33};
      vecs[15] = '{"mulhu_min_sq",  MULHU,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33};
      vecs[16] = '{"div_7_m2",      DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
      vecs[17] = '{"rem_7_m2",      REM,    32'd7,          32'hFFFF_FFFE,  32'd1,          33};

      // Reset values.
      #1;
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);

      foreach (vecs[i]) begin
         issue(vecs[i].f, vecs[i].a, vecs[i].b);
         check({vecs[i].name, "_accept"}, 32'(busy), 32'd1);
         wait_resp(n);
         check({vecs[i].name, "_latency"}, n, vecs[i].lat);
         check({vecs[i].name, "_data"}, resp_data, vecs[i].exp);
         consume();
      end

      // Back-pressure: result held, no new accept until the handshake completes.
      issue(MUL, 32'd3, 32'd4);
      wait_resp(n);
      check("hold_latency", n, 33);
      @(negedge clk);
      req_valid  = 1'b1;
      req_funct3 = MUL;
      req_a      = 32'd2;
      req_b      = 32'd9;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid_ready", {30'd0, resp_valid, req_ready}, 32'd2);
         check("hold_data", resp_data, 32'd12);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check("hold_no_overlap_busy", 32'(busy), 32'd0);
      check("hold_idle_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      check("hold_next_accept", 32'(busy), 32'd1);
      req_valid = 1'b0;
      wait_resp(n);
      check("hold_next_latency", n, 33);
      check("hold_next_data", resp_data, 32'd18);
      consume();

      // Flush mid-calculation: back to idle, response never issued.
      issue(MUL, 32'd7, 32'd7);
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_resp_valid", 32'(resp_valid), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (resp_valid) seen = 1'b1;
      end
      check("flush_no_resp", 32'(seen), 32'd0);

      // Flush blocks an accept in idle.
      @(negedge clk);
      flush      = 1'b1;
      req_valid  = 1'b1;
      req_funct3 = MUL;
      #1;
      check("flush_idle_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      check("flush_idle_no_accept", 32'(busy), 32'd0);
      flush     = 1'b0;
      req_valid = 1'b0;

      // Reset mid-calculation clears outputs at once.
      issue(MUL, 32'd9, 32'd9);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_resp_valid", 32'(resp_valid), 32'd0);
      check("midrst_resp_data", resp_data, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(MUL, 32'd3, 32'd5);
      wait_resp(n);
      check("post_rst_latency", n, 33);
      check("post_rst_data", resp_data, 32'd15);
      consume();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
